// File: rtl/his_reader_peak.sv
// Histogram bank reader: sweeps a completed ping-pong bank, streams every bin,
// clears each word behind the read and reports the peak bin of each pixel.
module his_reader_peak #(
  parameter int NB    = 8,
  parameter int CNT_W = 16,
  parameter int PIX_W = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              acq_done,
  input  logic              his_num,
  output logic              rd_en,
  output logic [PIX_W+NB:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              clr_en,
  output logic [PIX_W+NB:0] clr_addr,
  output logic              bin_valid,
  input  logic              bin_ready,
  output logic [CNT_W-1:0]  bin_data,
  output logic [NB-1:0]     bin_idx,
  output logic [PIX_W-1:0]  pix_idx,
  output logic              bin_last,
  output logic              peak_valid,
  output logic [NB-1:0]     peak_bin,
  output logic [CNT_W-1:0]  peak_count,
  output logic [PIX_W-1:0]  peak_pix,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_SEND,
    S_PEAK,
    S_DONE
  } state_t;

  localparam logic [NB-1:0]    BIN_LAST = '1;
  localparam logic [PIX_W-1:0] PIX_LAST = '1;

  state_t             state_q;
  logic               bank_q;
  logic [PIX_W-1:0]   pix_q;
  logic [NB-1:0]      bin_q;
  logic [CNT_W-1:0]   max_q;
  logic [NB-1:0]      peak_bin_q;
  logic [CNT_W-1:0]   bin_data_q;
  logic               rd_en_q;
  logic               clr_en_q;
  logic               bin_valid_q;
  logic               bin_last_q;
  logic               peak_valid_q;
  logic               done_q;
  logic               overrun_q;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_IDLE;
      bank_q       <= 1'b0;
      pix_q        <= '0;
      bin_q        <= '0;
      max_q        <= '0;
      peak_bin_q   <= '0;
      bin_data_q   <= '0;
      rd_en_q      <= 1'b0;
      clr_en_q     <= 1'b0;
      bin_valid_q  <= 1'b0;
      bin_last_q   <= 1'b0;
      peak_valid_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rd_en_q      <= 1'b0;
      clr_en_q     <= 1'b0;
      peak_valid_q <= 1'b0;
      done_q       <= 1'b0;
      // A new acquisition cannot be taken mid-sweep, including the DONE cycle.
      if (acq_done && state_q != S_IDLE)
        overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (acq_done) begin
            bank_q     <= his_num;
            pix_q      <= '0;
            bin_q      <= '0;
            max_q      <= '0;
            peak_bin_q <= '0;
            overrun_q  <= 1'b0;
            rd_en_q    <= 1'b1;
            state_q    <= S_RD;
          end
        end
        S_RD: begin
          clr_en_q <= 1'b1;
          state_q  <= S_LAT;
        end
        S_LAT: begin
          bin_data_q  <= rd_data;
          // Strict compare keeps the lowest bin index on ties.
          if (rd_data > max_q) begin
            max_q      <= rd_data;
            peak_bin_q <= bin_q;
          end
          bin_valid_q <= 1'b1;
          bin_last_q  <= (bin_q == BIN_LAST);
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (bin_ready) begin
            bin_valid_q <= 1'b0;
            bin_last_q  <= 1'b0;
            if (bin_q == BIN_LAST) begin
              peak_valid_q <= 1'b1;
              state_q      <= S_PEAK;
            end else begin
              bin_q   <= bin_q + 1'b1;
              rd_en_q <= 1'b1;
              state_q <= S_RD;
            end
          end
        end
        S_PEAK: begin
          if (pix_q == PIX_LAST) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            pix_q      <= pix_q + 1'b1;
            bin_q      <= '0;
            max_q      <= '0;
            peak_bin_q <= '0;
            rd_en_q    <= 1'b1;
            state_q    <= S_RD;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The address is stable from RD through LAT, so the clear hits the word just read.
  assign rd_addr    = {bank_q, pix_q, bin_q};
  assign clr_addr   = {bank_q, pix_q, bin_q};
  assign rd_en      = rd_en_q;
  assign clr_en     = clr_en_q;
  assign bin_valid  = bin_valid_q;
  assign bin_data   = bin_data_q;
  assign bin_idx    = bin_q;
  assign pix_idx    = pix_q;
  assign bin_last   = bin_last_q;
  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_count = max_q;
  assign peak_pix   = pix_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_his_reader_peak.sv
// Directed bench for his_reader_peak (NB=3, PIX_W=1) with a behavioural BRAM
// that has a one-cycle registered read and a zero-write clear port.
module tb_his_reader_peak;
  localparam int NB    = 3;
  localparam int CNT_W = 16;
  localparam int PIX_W = 1;
  localparam int AW    = 1 + PIX_W + NB;
  localparam int NW    = 1 << AW;

  typedef logic [15:0] bins_t [8];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              res, acq_done, his_num, bin_ready;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_en, clr_en, bin_valid, bin_last, peak_valid, busy, done, overrun;
  logic [AW-1:0]     rd_addr, clr_addr;
  logic [CNT_W-1:0]  bin_data, peak_count;
  logic [NB-1:0]     bin_idx, peak_bin;
  logic [PIX_W-1:0]  pix_idx, peak_pix;

  his_reader_peak #(.NB(NB), .CNT_W(CNT_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .res(res), .acq_done(acq_done), .his_num(his_num),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_en(clr_en), .clr_addr(clr_addr),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_data(bin_data),
    .bin_idx(bin_idx), .pix_idx(pix_idx), .bin_last(bin_last),
    .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_count(peak_count),
    .peak_pix(peak_pix), .busy(busy), .done(done), .overrun(overrun)
  );

  wire all_zero = ~|{rd_en, rd_addr, clr_en, clr_addr, bin_valid, bin_data, bin_idx,
                     pix_idx, bin_last, peak_valid, peak_bin, peak_count, peak_pix,
                     busy, done, overrun};

  // BRAM model, with a preload port used only while the DUT is idle
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [15:0]   pl_data;
  logic [15:0]   mem [NW];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (clr_en) mem[clr_addr] <= '0;
    if (pl_we) mem[pl_addr] <= pl_data;
  end

  int errors = 0;
  int checks = 0;

  // sweep records
  logic [15:0] got_data [64];
  int          got_bin [64];
  int          got_pix [64];
  logic        got_last [64];
  int          nbins, npeaks, ndone, sweep_cycles, bad_bank, stall_good, rd_after_done;
  int          pk_bin [8];
  int          pk_cnt [8];
  int          pk_pix [8];
  int          clr_cnt [NW];
  logic        first_rd_ok, ovr_at_start, timeout;

  task automatic preload_pix(input logic bank, input logic pix, input bins_t v);
    for (int i = 0; i < 8; i++) begin
      pl_we   = 1'b1;
      pl_addr = {bank, pix, 3'(i)};
      pl_data = v[i];
      @(negedge clk);
    end
    pl_we = 1'b0;
  endtask

  task automatic zero_mem();
    for (int i = 0; i < NW; i++) begin
      pl_we   = 1'b1;
      pl_addr = AW'(i);
      pl_data = '0;
      @(negedge clk);
    end
    pl_we = 1'b0;
  endtask

  // Starts a sweep and records everything; cycle 0 is the cycle after acq_done.
  task automatic run_sweep(input logic bank, input int stall_k, input int stall_len,
                           input logic [15:0] stall_exp, input int acq_at);
    int   stall_ctr;
    int   post;
    logic rdy;
    nbins = 0; npeaks = 0; ndone = 0; sweep_cycles = 0; bad_bank = 0;
    stall_good = 0; rd_after_done = 0; timeout = 1'b1;
    stall_ctr = 0; post = 0;
    for (int i = 0; i < NW; i++) clr_cnt[i] = 0;
    his_num = bank; acq_done = 1'b1; bin_ready = 1'b1;
    @(negedge clk);
    acq_done = 1'b0;
    first_rd_ok  = (rd_en === 1'b1);
    ovr_at_start = overrun;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (rd_en === 1'b1) begin
        if (rd_addr[AW-1] !== bank) bad_bank++;
        if (ndone > 0) rd_after_done++;
      end
      if (clr_en === 1'b1) begin
        if (clr_addr[AW-1] !== bank) bad_bank++;
        clr_cnt[clr_addr]++;
      end
      if (peak_valid === 1'b1 && npeaks < 8) begin
        pk_bin[npeaks] = int'(peak_bin);
        pk_cnt[npeaks] = int'(peak_count);
        pk_pix[npeaks] = int'(peak_pix);
        npeaks++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) sweep_cycles = cyc + 1;
      end
      rdy = 1'b1;
      if (nbins == stall_k && stall_ctr < stall_len && (stall_ctr > 0 || bin_valid === 1'b1)) begin
        rdy = 1'b0;
        stall_ctr++;
        if (bin_valid === 1'b1 && bin_data === stall_exp) stall_good++;
      end
      if (bin_valid === 1'b1 && rdy && nbins < 64) begin
        got_data[nbins] = bin_data;
        got_bin[nbins]  = int'(bin_idx);
        got_pix[nbins]  = int'(pix_idx);
        got_last[nbins] = bin_last;
        nbins++;
      end
      bin_ready = rdy;
      acq_done  = (cyc == acq_at);
      if (ndone > 0) begin
        post++;
        if (post > 6) begin
          timeout = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    acq_done  = 1'b0;
    bin_ready = 1'b1;
  endtask

  task automatic test_reset();
    res = 1'b1; acq_done = 1'b0; his_num = 1'b0; bin_ready = 1'b0; pl_we = 1'b0;
    pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_zero !== 1'b1) $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    if (all_zero !== 1'b1) errors++;
    zero_mem();
    acq_done = 1'b1; his_num = 1'b1;
    @(negedge clk);
    res = 1'b0; acq_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins: busy=%b rd_en=%b expected 0 0", busy, rd_en);
    end
  endtask

  task automatic test_sweep();
    bins_t p0;
    int    nz;
    p0 = '{16'd0, 16'd2, 16'd5, 16'd1, 16'd5, 16'd0, 16'd0, 16'd3};
    preload_pix(1'b0, 1'b0, p0);
    run_sweep(1'b0, -1, 0, 16'd0, -1);
    checks++;
    if (timeout !== 1'b0 || nbins != 16) begin
      errors++;
      $display("FAIL sweep_count: bins=%0d timeout=%b expected 16 0", nbins, timeout);
    end
    checks++;
    if (first_rd_ok !== 1'b1) begin
      errors++;
      $display("FAIL first_rd_latency: rd_en=%b one cycle after acq_done, expected 1", first_rd_ok);
    end
    for (int k = 0; k < 16 && k < nbins; k++) begin
      checks++;
      if (got_data[k] !== ((k < 8) ? p0[k] : 16'd0) || got_bin[k] != k % 8 ||
          got_pix[k] != k / 8 || got_last[k] !== (k % 8 == 7)) begin
        errors++;
        $display("FAIL sweep_bin%0d: data=%0d bin=%0d pix=%0d last=%b expected %0d %0d %0d %b",
                 k, got_data[k], got_bin[k], got_pix[k], got_last[k],
                 (k < 8) ? p0[k] : 16'd0, k % 8, k / 8, (k % 8 == 7));
      end
    end
    checks++;
    if (npeaks != 2 || pk_pix[0] != 0 || pk_bin[0] != 2 || pk_cnt[0] != 5) begin
      errors++;
      $display("FAIL peak_pix0: n=%0d pix=%0d bin=%0d cnt=%0d expected 2 0 2 5",
               npeaks, pk_pix[0], pk_bin[0], pk_cnt[0]);
    end
    checks++;
    if (pk_pix[1] != 1 || pk_bin[1] != 0 || pk_cnt[1] != 0) begin
      errors++;
      $display("FAIL peak_pix1_zero: pix=%0d bin=%0d cnt=%0d expected 1 0 0",
               pk_pix[1], pk_bin[1], pk_cnt[1]);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL done_once: got %0d pulses expected 1", ndone);
    end
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 16'd0) nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL sweep_cleared: %0d nonzero words expected 0", nz);
    end
  endtask

  task automatic test_backpressure();
    bins_t p0;
    int    nz, bad_clr;
    p0 = '{16'd0, 16'd2, 16'd5, 16'd1, 16'd5, 16'd0, 16'd0, 16'd3};
    preload_pix(1'b0, 1'b0, p0);
    run_sweep(1'b0, 3, 10, 16'd1, -1);
    checks++;
    if (stall_good != 10) begin
      errors++;
      $display("FAIL stall_hold: stable cycles=%0d expected 10", stall_good);
    end
    checks++;
    if (nbins != 16 || got_data[3] !== 16'd1 || got_data[4] !== 16'd5) begin
      errors++;
      $display("FAIL stall_stream: bins=%0d bin3=%0d bin4=%0d expected 16 1 5",
               nbins, got_data[3], got_data[4]);
    end
    checks++;
    if (clr_cnt[3] != 1) begin
      errors++;
      $display("FAIL stall_clr3: got %0d clears expected 1", clr_cnt[3]);
    end
    bad_clr = 0; nz = 0;
    for (int i = 0; i < 16; i++) begin
      if (clr_cnt[i] != 1) bad_clr++;
      if (mem[i] !== 16'd0) nz++;
    end
    checks++;
    if (bad_clr != 0 || nz != 0) begin
      errors++;
      $display("FAIL stall_bank_clear: bad clear counts=%0d nonzero=%0d expected 0 0", bad_clr, nz);
    end
  endtask

  task automatic test_bank_select();
    bins_t m0, m1, q0, q1;
    int    bad0, nz1;
    for (int i = 0; i < 8; i++) begin
      m0[i] = 16'hA0 + 16'(i);
      m1[i] = 16'hB0 + 16'(i);
      q0[i] = 16'd1;
      q1[i] = 16'd0;
    end
    q1[7] = 16'd9;
    preload_pix(1'b0, 1'b0, m0);
    preload_pix(1'b0, 1'b1, m1);
    preload_pix(1'b1, 1'b0, q0);
    preload_pix(1'b1, 1'b1, q1);
    run_sweep(1'b1, -1, 0, 16'd0, -1);
    checks++;
    if (bad_bank != 0 || nbins != 16) begin
      errors++;
      $display("FAIL bank1_addr: wrong-bank strobes=%0d bins=%0d expected 0 16", bad_bank, nbins);
    end
    checks++;
    if (got_data[0] !== 16'd1 || got_data[14] !== 16'd0 || got_data[15] !== 16'd9) begin
      errors++;
      $display("FAIL bank1_data: b0=%0d b14=%0d b15=%0d expected 1 0 9",
               got_data[0], got_data[14], got_data[15]);
    end
    checks++;
    if (npeaks != 2 || pk_bin[0] != 0 || pk_cnt[0] != 1 || pk_bin[1] != 7 || pk_cnt[1] != 9) begin
      errors++;
      $display("FAIL bank1_peaks: n=%0d (%0d,%0d) (%0d,%0d) expected 2 (0,1) (7,9)",
               npeaks, pk_bin[0], pk_cnt[0], pk_bin[1], pk_cnt[1]);
    end
    bad0 = 0; nz1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem[i] !== m0[i]) bad0++;
      if (mem[8 + i] !== m1[i]) bad0++;
      if (mem[16 + i] !== 16'd0 || mem[24 + i] !== 16'd0) nz1++;
    end
    checks++;
    if (bad0 != 0 || nz1 != 0) begin
      errors++;
      $display("FAIL bank0_untouched: changed bank0 words=%0d nonzero bank1 words=%0d expected 0 0",
               bad0, nz1);
    end
  endtask

  task automatic test_overrun();
    bins_t p0;
    zero_mem();
    p0 = '{16'd0, 16'd2, 16'd5, 16'd1, 16'd5, 16'd0, 16'd0, 16'd3};
    preload_pix(1'b0, 1'b0, p0);
    run_sweep(1'b0, -1, 0, 16'd0, 20);
    checks++;
    if (nbins != 16 || ndone != 1 || sweep_cycles != 51 || got_data[2] !== 16'd5) begin
      errors++;
      $display("FAIL overrun_sweep: bins=%0d done=%0d cycles=%0d bin2=%0d expected 16 1 51 5",
               nbins, ndone, sweep_cycles, got_data[2]);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    // acq_done during the DONE cycle is still counted as busy
    run_sweep(1'b0, -1, 0, 16'd0, 50);
    checks++;
    if (ovr_at_start !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b after accepted acq_done expected 0", ovr_at_start);
    end
    checks++;
    if (overrun !== 1'b1 || rd_after_done != 0 || ndone != 1) begin
      errors++;
      $display("FAIL overrun_done_cycle: overrun=%b restarts=%0d done=%0d expected 1 0 1",
               overrun, rd_after_done, ndone);
    end
  endtask

  task automatic test_timing();
    run_sweep(1'b0, -1, 0, 16'd0, -1);
    checks++;
    if (sweep_cycles != 51 || first_rd_ok !== 1'b1) begin
      errors++;
      $display("FAIL sweep_timing: cycles=%0d first_rd=%b expected 51 1", sweep_cycles, first_rd_ok);
    end
    checks++;
    if (ovr_at_start !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL timing_overrun: start=%b end=%b expected 0 0", ovr_at_start, overrun);
    end
  endtask

  task automatic test_reset_abort();
    bins_t p;
    logic  found;
    int    strobes, bad;
    zero_mem();
    for (int i = 0; i < 8; i++) p[i] = 16'(i + 1);
    preload_pix(1'b0, 1'b0, p);
    his_num = 1'b0; acq_done = 1'b1; bin_ready = 1'b1;
    @(negedge clk);
    acq_done = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bin_valid === 1'b1 && bin_idx === 3'd4) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_bin4: found=%b expected 1", found);
    end
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    checks++;
    if (all_zero !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b rd_en=%b clr_en=%b bin_valid=%b expected all 0",
               busy, rd_en, clr_en, bin_valid);
    end
    res = 1'b0;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      if (rd_en === 1'b1 || clr_en === 1'b1 || busy === 1'b1) strobes++;
      @(negedge clk);
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL abort_idle: active cycles=%0d expected 0", strobes);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) if (mem[i] !== 16'd0) bad++;
    for (int i = 5; i < 8; i++) if (mem[i] !== 16'(i + 1)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_contents: bins5..7=%0d,%0d,%0d bad=%0d expected 6,7,8 bad=0",
               mem[5], mem[6], mem[7], bad);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    $display("test_reset done: errors=%0d", errors);
    test_sweep();
    $display("test_sweep done: errors=%0d", errors);
    test_backpressure();
    $display("test_backpressure done: errors=%0d", errors);
    test_bank_select();
    $display("test_bank_select done: errors=%0d", errors);
    test_overrun();
    $display("test_overrun done: errors=%0d", errors);
    test_timing();
    $display("test_timing done: errors=%0d", errors);
    test_reset_abort();
    $display("test_reset_abort done: errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/his_reader_peak.md
Name: his_reader_peak

Overview:
Read side of the histogram BRAM that the histogram builder fills. On each acquisition-finish pulse it sweeps the completed ping-pong bank pixel by pixel and bin by bin. Each bin count is streamed downstream on a valid/ready interface, and each bin is cleared behind the read so the bank is zeroed for the next acquisition. After the last bin of every pixel it reports that pixel's peak bin for time-of-flight extraction.

Parameters:
NB, 8, bin address width; bins per pixel = 2**NB
CNT_W, 16, bin count width
PIX_W, 2, pixel index width; pixels per RAM bank = 2**PIX_W

Ports:
clk  in  1  system clock
res  in  1  synchronous active-high reset
acq_done  in  1  one-cycle pulse from the builder when an acquisition completes
his_num  in  1  bank just completed by the builder; sampled with acq_done
rd_en  out  1  BRAM read strobe
rd_addr  out  1+PIX_W+NB  BRAM address {bank, pix, bin}
rd_data  in  CNT_W  BRAM read data, valid exactly 1 cycle after rd_en
clr_en  out  1  BRAM write strobe; write data is always zero
clr_addr  out  1+PIX_W+NB  address being cleared
bin_valid  out  1  bin_data/bin_idx/pix_idx valid
bin_ready  in  1  downstream accepts the bin
bin_data  out  CNT_W  bin count
bin_idx  out  NB  bin index
pix_idx  out  PIX_W  pixel index
bin_last  out  1  high with bin_valid on the last bin of a pixel
peak_valid  out  1  one-cycle peak report
peak_bin  out  NB  index of the max bin
peak_count  out  CNT_W  count of the max bin
peak_pix  out  PIX_W  pixel of this report
busy  out  1  sweep in progress
done  out  1  one-cycle pulse when the bank sweep completes
overrun  out  1  sticky; set when acq_done arrives while busy

Behaviour:
- Reset (res=1 at a clk edge): state IDLE. All outputs are 0, including overrun. Internal max, pix and bin registers are 0. Reset during a sweep aborts it, with no further reads or clears; the remaining bins keep their contents.
- FSM states:
  - IDLE: on acq_done, latch bank=his_num, set pix=0, bin=0, max=0, peak_bin=0, clear overrun, then go to RD.
  - RD: rd_en=1 for one cycle with rd_addr={bank,pix,bin}, then go to LAT.
  - LAT: capture rd_data into bin_data. In the same cycle, clr_en=1 with clr_addr={bank,pix,bin}. If rd_data > max (strictly greater), update max and peak_bin to bin. Go to SEND.
  - SEND: bin_valid=1 and outputs are held stable until bin_ready. On the handshake cycle: if bin == 2**NB-1, go to PEAK; otherwise increment bin and go to RD.
  - PEAK: peak_valid=1 for one cycle with peak_count=max and peak_pix=pix. If pix == 2**PIX_W-1, go to DONE; otherwise increment pix, reset bin, max and peak_bin to 0, and go to RD.
  - DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- Latency and throughput:
  - First rd_en occurs 1 cycle after acq_done.
  - With bin_ready tied high, each bin takes 3 cycles (RD, LAT, SEND).
  - A full sweep takes 2**PIX_W*(3*2**NB+1)+1 cycles from the first RD to done.
- Tie rule: on equal counts the lowest bin index wins.
- All-zero pixel: report peak_bin=0 and peak_count=0.
- Counts are passed through unmodified; there is no saturation or arithmetic on bin_data.
- Backpressure: bin_valid must not drop and bin_data must not change until the handshake. Each bin is cleared exactly once, in LAT, regardless of stall length.
- acq_done while busy: ignored and the sweep continues; overrun is set to 1 and held until the next accepted acq_done in IDLE.
- acq_done in the DONE cycle counts as busy: overrun is set.
- acq_done in the same cycle as res: reset wins.
- bin_ready outside SEND has no effect.

Test Plan:
1. NB=3, PIX_W=1. Preload bank 0 pixel 0 bins {0,2,5,1,5,0,0,3} and pixel 1 all zero; pulse acq_done with his_num=0. Required: 16 bins stream in order with bin_last on bins 7 and 15. Pixel 0 peak reports peak_bin=2, peak_count=5 (tie rule). Pixel 1 peak reports peak_bin=0, peak_count=0. done pulses once.
2. Same preload, bin_ready held low 10 cycles on bin 3. Required: bin_valid held, bin_data=1 stable throughout. Exactly one clr_en for address 3. Afterwards every BRAM word of bank 0 reads 0.
3. Preload bank 1 only; pulse acq_done with his_num=1. Required: every rd_addr and clr_addr has MSB=1, and bank 0 is untouched.
4. Pulse acq_done again mid-sweep. Required: the sweep is unaffected and overrun=1 until the next accepted acq_done, which clears it.
5. Assert res after pixel 0 bin 4 is accepted. Required: next cycle all outputs are 0 and the state is IDLE. Bins 5..7 keep their preload values.
6. bin_ready tied high, NB=3, PIX_W=1. Required: 51 cycles from the first rd_en to done.
